// File: rtl/ks_pkg.sv
// ks_pkg: shared Kogge-Stone constants and helpers
package ks_pkg;
  localparam int S1_LEVELS = 2;
  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/ks_prefix_level.sv
// ks_prefix_level: one combinational Kogge-Stone level spanning DIST bits
module ks_prefix_level #(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g_next,
  output logic [WIDTH-1:0] p_next
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < DIST) begin : g_pass
      assign g_next[i] = g[i];
      assign p_next[i] = p[i];
    end else if (i < 2 * DIST) begin : g_grey
      assign g_next[i] = g[i] | (p[i] & g[i-DIST]);
      assign p_next[i] = p[i];
    end else begin : g_black
      assign g_next[i] = g[i] | (p[i] & g[i-DIST]);
      assign p_next[i] = p[i] & p[i-DIST];
    end
  end
endmodule

// File: rtl/ks_addsub_pipe.sv
// ks_addsub_pipe: three-stage handshaked Kogge-Stone adder/subtractor with flags
module ks_addsub_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sub,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_borrow,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_neg,
  output logic [TAG_W-1:0] o_tag
);
  localparam int LEVELS = ks_levels(WIDTH);
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p_save;
    logic             c0;
    logic             sub;
    logic [TAG_W-1:0] tag;
  } ks_gp_t;
  typedef struct packed {
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] p_save;
    logic             sub;
    logic [TAG_W-1:0] tag;
  } ks_carry_t;
  if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32) begin : g_bad_width
    $error("ks_addsub_pipe: WIDTH must be 8, 16 or 32, got %0d", WIDTH);
  end
  logic             v1, v2, adv1, adv2, adv3, c0;
  logic [WIDTH-1:0] b_x, p0, g0, sum_d;
  logic [WIDTH-1:0] gn [0:LEVELS];
  logic [WIDTH-1:0] pn [0:LEVELS];
  logic             unused_p;
  ks_gp_t           s1;
  ks_carry_t        s2;
  assign b_x   = i_b ^ {WIDTH{i_sub}};
  assign c0    = i_sub | i_cin;
  assign p0    = i_a ^ b_x;
  assign g0    = i_a & b_x;
  assign gn[0] = {g0[WIDTH-1:1], g0[0] | (p0[0] & c0)};
  assign pn[0] = p0;
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    if (l == S1_LEVELS) begin : g_from_s1
      ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << l)) u_level (
        .g(s1.g), .p(s1.p), .g_next(gn[l+1]), .p_next(pn[l+1])
      );
    end else begin : g_chain
      ks_prefix_level #(.WIDTH(WIDTH), .DIST(1 << l)) u_level (
        .g(gn[l]), .p(pn[l]), .g_next(gn[l+1]), .p_next(pn[l+1])
      );
    end
  end
  assign unused_p = ^pn[LEVELS];
  assign adv3     = ~o_valid | i_ready;
  assign adv2     = ~v2 | adv3;
  assign adv1     = ~v1 | adv2;
  assign o_ready  = adv1;
  assign sum_d    = s2.p_save ^ s2.c[WIDTH-1:0];
  // stage valids: each stage takes its upstream valid whenever it may advance
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      if (adv1) v1 <= i_valid;
      if (adv2) v2 <= v1;
      if (adv3) o_valid <= v2;
    end
  end
  // S1/S2 data: only real operations are captured, so bubbles never disturb held data
  always_ff @(posedge i_clk) begin
    if (adv1 && i_valid) s1 <= '{g: gn[S1_LEVELS], p: pn[S1_LEVELS], p_save: p0, c0: c0, sub: i_sub, tag: i_tag};
    if (adv2 && v1) s2 <= '{c: {gn[LEVELS], s1.c0}, p_save: s1.p_save, sub: s1.sub, tag: s1.tag};
  end
  // S3: sum and flags, cleared on reset and updated only from a valid S2
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sum    <= '0;
      o_cout   <= 1'b0;
      o_borrow <= 1'b0;
      o_ovf    <= 1'b0;
      o_zero   <= 1'b0;
      o_neg    <= 1'b0;
      o_tag    <= '0;
    end else if (adv3 && v2) begin
      o_sum    <= sum_d;
      o_cout   <= s2.c[WIDTH];
      o_borrow <= s2.sub & ~s2.c[WIDTH];
      o_ovf    <= s2.c[WIDTH] ^ s2.c[WIDTH-1];
      o_zero   <= sum_d == '0;
      o_neg    <= sum_d[WIDTH-1];
      o_tag    <= s2.tag;
    end
  end
endmodule

// File: tb/tb_ks_addsub_pipe.sv
// tb_ks_addsub_pipe: directed and randomized checks of ks_addsub_pipe at widths 8, 16 and 32
module tb_ks_addsub_pipe;
  logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, sub = 1'b0, cin = 1'b0, rdy = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  tag = '0;
  logic        ordy [3];
  logic        ovld [3];
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [4:0]  f8, f16, f32;
  logic [3:0]  t8, t16, t32;
  logic [40:0] obs [3];
  logic [40:0] q [3][$];
  int          wd [3] = '{8, 16, 32};
  int          checks = 0, passed = 0;

  always #5 clk = ~clk;

  ks_addsub_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ordy[0]), .i_sub(sub), .i_cin(cin),
    .i_a(a[7:0]), .i_b(b[7:0]), .i_tag(tag), .o_valid(ovld[0]), .i_ready(rdy), .o_sum(s8),
    .o_cout(f8[4]), .o_borrow(f8[3]), .o_ovf(f8[2]), .o_zero(f8[1]), .o_neg(f8[0]), .o_tag(t8));
  ks_addsub_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ordy[1]), .i_sub(sub), .i_cin(cin),
    .i_a(a[15:0]), .i_b(b[15:0]), .i_tag(tag), .o_valid(ovld[1]), .i_ready(rdy), .o_sum(s16),
    .o_cout(f16[4]), .o_borrow(f16[3]), .o_ovf(f16[2]), .o_zero(f16[1]), .o_neg(f16[0]), .o_tag(t16));
  ks_addsub_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ordy[2]), .i_sub(sub), .i_cin(cin),
    .i_a(a), .i_b(b), .i_tag(tag), .o_valid(ovld[2]), .i_ready(rdy), .o_sum(s32),
    .o_cout(f32[4]), .o_borrow(f32[3]), .o_ovf(f32[2]), .o_zero(f32[1]), .o_neg(f32[0]), .o_tag(t32));

  // result word layout: {sum[31:0], cout, borrow, ovf, zero, neg, tag[3:0]}
  always_comb begin
    obs[0] = {24'd0, s8, f8, t8};
    obs[1] = {16'd0, s16, f16, t16};
    obs[2] = {s32, f32, t32};
  end

  // reference: integer arithmetic on unsigned and signed operand values
  function automatic logic [40:0] model(int w, logic [31:0] x, logic [31:0] y, logic s, logic ci, logic [3:0] t);
    longint m, ua, ub, sa, sb, r, sm;
    logic   co, ov;
    m  = (longint'(1) << w) - 1;
    ua = longint'({32'd0, x}) & m;
    ub = longint'({32'd0, y}) & m;
    sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
    sb = ub[w-1] ? ub - (longint'(1) << w) : ub;
    if (s) begin
      sm = (ua - ub) & m;
      co = ua >= ub;
      r  = sa - sb;
    end else begin
      sm = (ua + ub + longint'(ci)) & m;
      co = (ua + ub + longint'(ci)) > m;
      r  = sa + sb + longint'(ci);
    end
    ov = (r < -(longint'(1) << (w - 1))) || (r > (longint'(1) << (w - 1)) - 1);
    return {sm[31:0], co, s & ~co, ov, sm == 0, sm[w-1], t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; a = $urandom; b = $urandom; tag = 4'hA;
    tick(); tick();
    rst = 1'b0; valid = 1'b0;
    checks++; if (ordy[1] !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", ordy[1]); else passed++;
    checks++; if (ovld[1] !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", ovld[1]); else passed++;
    checks++; if (obs[1] !== 41'd0) $display("FAIL reset_outputs: got %h expected 0", obs[1]); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ovld[1] !== 1'b0) $display("FAIL reset_no_emit: got o_valid=%0b expected 0", ovld[1]); else passed++;
    end
  endtask

  // single operation on the 16-bit unit: valid after the third edge counting the accepting one
  task automatic test_op(string name, logic [15:0] x, logic [15:0] y, logic s, logic ci, logic [3:0] t, logic [40:0] exp);
    rdy = 1'b1; a = {16'd0, x}; b = {16'd0, y}; sub = s; cin = ci; tag = t; valid = 1'b1;
    #1;
    checks++; if (ordy[1] !== 1'b1) $display("FAIL %s ready: got %0b expected 1", name, ordy[1]); else passed++;
    tick();
    valid = 1'b0;
    checks++; if (ovld[1] !== 1'b0) $display("FAIL %s early1: got o_valid=%0b expected 0", name, ovld[1]); else passed++;
    tick();
    checks++; if (ovld[1] !== 1'b0) $display("FAIL %s early2: got o_valid=%0b expected 0", name, ovld[1]); else passed++;
    tick();
    checks++; if (ovld[1] !== 1'b1) $display("FAIL %s latency: got o_valid=%0b expected 1", name, ovld[1]); else passed++;
    checks++; if (obs[1] !== exp) $display("FAIL %s result: got %h expected %h", name, obs[1], exp); else passed++;
    tick();
    checks++; if (ovld[1] !== 1'b0) $display("FAIL %s retire: got o_valid=%0b expected 0", name, ovld[1]); else passed++;
  endtask

  task automatic test_add_sub();
    test_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h1, {32'h0000_0000, 5'b10010, 4'h1});
    test_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'h2, {32'h0000_8000, 5'b00101, 4'h2});
    test_op("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b0, 4'h3, {32'h0000_FFFE, 5'b01001, 4'h3});
    test_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b1, 4'h4, {32'h0000_7FFF, 5'b10100, 4'h4});
    test_op("sub_zero",   16'h0000, 16'h0000, 1'b1, 1'b0, 4'h5, {32'h0000_0000, 5'b10010, 4'h5});
    test_op("add_cin",    16'h00FF, 16'h0F00, 1'b0, 1'b1, 4'h6, {32'h0000_1000, 5'b00000, 4'h6});
    test_op("add_negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 4'h7, {32'h0000_0000, 5'b10110, 4'h7});
  endtask

  task automatic test_back_to_back();
    logic [40:0] bq [$];
    int          issued = 0, got = 0;
    bit          dropped = 0, acc;
    rdy = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom); tag = 4'd0; valid = 1'b1;
    for (int c = 0; c < 60 && got < 8; c++) begin
      rdy = !(c >= 4 && c <= 7);
      #1;
      checks++;
      if (ordy[1] !== (bq.size() < 3 || rdy)) $display("FAIL b2b_ready c%0d: got %0b expected %0b", c, ordy[1], bq.size() < 3 || rdy);
      else passed++;
      if (!ordy[1]) dropped = 1;
      if (ovld[1]) begin
        checks++;
        if (bq.size() == 0) $display("FAIL b2b_extra: got output %h expected none", obs[1]);
        else if (obs[1] !== bq[0]) $display("FAIL b2b_result c%0d: got %h expected %h", c, obs[1], bq[0]);
        else passed++;
        if (rdy && bq.size() > 0) begin
          void'(bq.pop_front());
          got++;
        end
      end
      acc = valid & ordy[1];
      if (acc) bq.push_back(model(16, a, b, sub, cin, tag));
      tick();
      if (acc) begin
        issued++;
        if (issued < 8) begin
          a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom); tag = 4'(issued);
        end else valid = 1'b0;
      end
    end
    valid = 1'b0; rdy = 1'b1;
    checks++; if (got !== 8) $display("FAIL b2b_count: got %0d expected 8", got); else passed++;
    checks++; if (dropped !== 1'b1) $display("FAIL b2b_stall: got o_ready_dropped=%0b expected 1", dropped); else passed++;
  endtask

  task automatic test_reset_midflight();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom); tag = 4'(8 + i); valid = 1'b1;
      tick();
    end
    valid = 1'b0;
    checks++; if (ordy[1] !== 1'b0) $display("FAIL mid_full: got o_ready=%0b expected 0", ordy[1]); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0; rdy = 1'b1;
    checks++; if (ovld[1] !== 1'b0) $display("FAIL mid_flush: got o_valid=%0b expected 0", ovld[1]); else passed++;
    checks++; if (ordy[1] !== 1'b1) $display("FAIL mid_ready: got o_ready=%0b expected 1", ordy[1]); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ovld[1] !== 1'b0) $display("FAIL mid_no_emit: got o_valid=%0b expected 0", ovld[1]); else passed++;
    end
    test_op("post_reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 4'h9, {32'h0000_2345, 5'b00000, 4'h9});
  endtask

  task automatic test_random();
    int  accepted = 0;
    bit  acc16 = 0, acc;
    valid = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) q[d].delete();
    for (int c = 0; c < 40000 && accepted < 10000; c++) begin
      if (!valid || acc16) begin
        a   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        b   = ($urandom_range(0, 7) == 0) ? 32'h0000_0000 : $urandom;
        sub = 1'($urandom); cin = 1'($urandom); tag = 4'($urandom);
        valid = $urandom_range(0, 3) != 0;
      end
      rdy = $urandom_range(0, 3) != 0;
      #1;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (ordy[d] !== (q[d].size() < 3 || rdy)) $display("FAIL rnd_ready w%0d c%0d: got %0b expected %0b", wd[d], c, ordy[d], q[d].size() < 3 || rdy);
        else passed++;
        if (ovld[d]) begin
          checks++;
          if (q[d].size() == 0) $display("FAIL rnd_extra w%0d: got output %h expected none", wd[d], obs[d]);
          else if (obs[d] !== q[d][0]) $display("FAIL rnd_result w%0d c%0d: got %h expected %h", wd[d], c, obs[d], q[d][0]);
          else passed++;
          if (rdy && q[d].size() > 0) void'(q[d].pop_front());
        end
        acc = valid & ordy[d];
        if (acc) q[d].push_back(model(wd[d], a, b, sub, cin, tag));
        if (d == 1) acc16 = acc;
      end
      if (acc16) accepted++;
      tick();
    end
    valid = 1'b0; rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      for (int d = 0; d < 3; d++) begin
        if (ovld[d]) begin
          checks++;
          if (q[d].size() == 0) $display("FAIL drain_extra w%0d: got output %h expected none", wd[d], obs[d]);
          else if (obs[d] !== q[d][0]) $display("FAIL drain_result w%0d: got %h expected %h", wd[d], obs[d], q[d][0]);
          else passed++;
          if (q[d].size() > 0) void'(q[d].pop_front());
        end
      end
      tick();
    end
    checks++; if (accepted < 10000) $display("FAIL rnd_accepted: got %0d expected 10000", accepted); else passed++;
    for (int d = 0; d < 3; d++) begin
      checks++; if (q[d].size() != 0) $display("FAIL rnd_lost w%0d: got %0d pending expected 0", wd[d], q[d].size()); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
